// File: rtl/btn_cond_pkg.sv
// Shared constants and FSM state type for the camera push-button conditioner.
package btn_cond_pkg;

  localparam int NUM_BTN       = 6;
  localparam int BTN_LEFT      = 0;
  localparam int BTN_RIGHT     = 1;
  localparam int BTN_UP        = 2;
  localparam int BTN_DOWN      = 3;
  localparam int BTN_ROT_LEFT  = 4;
  localparam int BTN_ROT_RIGHT = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEB_ON  = 3'd1,
    HELD    = 3'd2,
    REPEAT  = 3'd3,
    DEB_OFF = 3'd4
  } btn_state_t;

  // Counter must reach (largest cycle parameter - 1); never narrower than one bit.
  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce/auto-repeat FSM and its counter.
// Auto-repeat exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic pulse_o,
  output logic clean_o
);

  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
`endif

  logic             s1_q;
  logic             s2_q;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_d;
  logic             clean_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decisions are combinational here; the top registers pulse and clean,
  // so an accepted press appears DEBOUNCE_CYCLES+2 edges after first sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = DEB_ON;
          cnt_d   = '0;
        end
      end
      DEB_ON: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = DEB_OFF;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (cnt_q == DELAY_LAST) begin
          state_d = REPEAT;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      REPEAT: begin
        if (!s2_q) begin
          state_d = DEB_OFF;
          cnt_d   = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEB_OFF: begin
        // A bounce back to pressed restarts the repeat delay without a step.
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    clean_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DEB_OFF);
  end

  assign pulse_o = pulse_d;
  assign clean_o = clean_d;

endmodule

// File: rtl/button_conditioner.sv
// Six-button conditioner feeding virtual_camera; opposing-pair pulse suppression
// and output registers. Auto-repeat is compiled in with BTN_AUTOREPEAT_EN.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic [NUM_BTN-1:0] btn_pulse
);

  logic [NUM_BTN-1:0] rawPulse;
  logic [NUM_BTN-1:0] cleanLvl;
  logic [NUM_BTN-1:0] pulse_d;
  logic [NUM_BTN-1:0] btnClean_q;
  logic [NUM_BTN-1:0] btnPulse_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : gChan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) uChan (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_raw[g]),
      .pulse_o(rawPulse[g]),
      .clean_o(cleanLvl[g])
    );
  end

  // Opposite directions stepping together would cancel; drop both instead.
  always_comb begin
    pulse_d = rawPulse;
    if (rawPulse[BTN_LEFT] && rawPulse[BTN_RIGHT]) begin
      pulse_d[BTN_LEFT]  = 1'b0;
      pulse_d[BTN_RIGHT] = 1'b0;
    end
    if (rawPulse[BTN_UP] && rawPulse[BTN_DOWN]) begin
      pulse_d[BTN_UP]   = 1'b0;
      pulse_d[BTN_DOWN] = 1'b0;
    end
    if (rawPulse[BTN_ROT_LEFT] && rawPulse[BTN_ROT_RIGHT]) begin
      pulse_d[BTN_ROT_LEFT]  = 1'b0;
      pulse_d[BTN_ROT_RIGHT] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btnClean_q <= '0;
      btnPulse_q <= '0;
    end else begin
      btnClean_q <= cleanLvl;
      btnPulse_q <= pulse_d;
    end
  end

  assign btn_clean = btnClean_q;
  assign btn_pulse = btnPulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; expectations follow BTN_AUTOREPEAT_EN when it is defined.
module tb_button_conditioner;

  typedef struct {
    int         cycle;
    logic [5:0] pulse;
    logic [5:0] clean;
    string      tag;
  } expEntry_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btn_raw = '0;
  logic [5:0] btn_clean;
  logic [5:0] btn_pulse;

  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  expEntry_t expQ[$];
  expEntry_t monEntry;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge when read on a falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExpect(input int cycle, input logic [5:0] pulse,
                            input logic [5:0] clean, input string tag);
    expEntry_t e;
    e.cycle = cycle;
    e.pulse = pulse;
    e.clean = clean;
    e.tag   = tag;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expEntry_t e);
    checks++;
    if (btn_pulse !== e.pulse) begin
      failures++;
      $display("[TB] FAIL %s_pulse cycle=%0d got=%b expected=%b", e.tag, cyc, btn_pulse, e.pulse);
    end
    checks++;
    if (btn_clean !== e.clean) begin
      failures++;
      $display("[TB] FAIL %s_clean cycle=%0d got=%b expected=%b", e.tag, cyc, btn_clean, e.clean);
    end
  endtask

  // Monitor: consumes scheduled expectations and flags any pulse nobody predicted.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cycle < cyc) begin
      monEntry = expQ.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s_missed cycle=%0d got=unvisited expected=cycle %0d",
               monEntry.tag, cyc, monEntry.cycle);
    end
    if (expQ.size() > 0 && expQ[0].cycle == cyc) begin
      monEntry = expQ.pop_front();
      checkOutput(monEntry);
    end else if (btn_pulse !== 6'b0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_pulse cycle=%0d got=%b expected=000000", cyc, btn_pulse);
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the pattern from the next rising edge for 'hold' samples, then releases.
  task automatic applyStimulus(input logic [5:0] pattern, input int hold);
    btn_raw = pattern;
    settle(hold);
    btn_raw = 6'b0;
  endtask

  initial begin
    int e0;
    $display("[TB] start");
    settle(2);
    pushExpect(cyc + 1, 6'h00, 6'h00, "reset");
    settle(1);
    settle(1);
    rst_n = 1'b1;
    settle(3);

    // Left held 10 samples: single press pulse, clean tracks press and release.
    e0 = cyc + 1;
    pushExpect(e0 + 5,  6'h00, 6'h00, "left_pre");
    pushExpect(e0 + 6,  6'h01, 6'h01, "left_press");
    pushExpect(e0 + 15, 6'h00, 6'h01, "left_rel_hold");
    pushExpect(e0 + 16, 6'h00, 6'h00, "left_rel_fall");
    applyStimulus(6'h01, 10);
    settle(12);

    // Up held 60 samples: auto-repeat train when compiled in.
    e0 = cyc + 1;
    pushExpect(e0 + 6,  6'h04, 6'h04, "up_press");
`ifdef BTN_AUTOREPEAT_EN
    pushExpect(e0 + 26, 6'h04, 6'h04, "up_rep1");
    pushExpect(e0 + 34, 6'h04, 6'h04, "up_rep2");
    pushExpect(e0 + 42, 6'h04, 6'h04, "up_rep3");
    pushExpect(e0 + 50, 6'h04, 6'h04, "up_rep4");
    pushExpect(e0 + 58, 6'h04, 6'h04, "up_rep5");
`else
    pushExpect(e0 + 26, 6'h00, 6'h04, "up_norep");
`endif
    pushExpect(e0 + 65, 6'h00, 6'h04, "up_rel_hold");
    pushExpect(e0 + 66, 6'h00, 6'h00, "up_rel_fall");
    applyStimulus(6'h04, 60);
    settle(10);

    // Right chattering every 2 samples never qualifies.
    e0 = cyc + 1;
    pushExpect(e0 + 6,  6'h00, 6'h00, "chatter_a");
    pushExpect(e0 + 12, 6'h00, 6'h00, "chatter_b");
    pushExpect(e0 + 16, 6'h00, 6'h00, "chatter_c");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'h02, 2);
      settle(2);
    end
    settle(8);

    // Rotation pair pressed together: pulses cancel, levels do not.
    e0 = cyc + 1;
    pushExpect(e0 + 6,  6'h00, 6'h30, "rot_pair");
    pushExpect(e0 + 15, 6'h00, 6'h30, "rot_pair_hold");
    pushExpect(e0 + 16, 6'h00, 6'h00, "rot_pair_fall");
    applyStimulus(6'h30, 10);
    settle(12);

    // Left and up are not opposing, so both step together.
    e0 = cyc + 1;
    pushExpect(e0 + 6,  6'h05, 6'h05, "left_up");
    pushExpect(e0 + 16, 6'h00, 6'h00, "left_up_fall");
    applyStimulus(6'h05, 10);
    settle(12);

    // Down held through a one-cycle reset at e0+15: outputs clear, then fresh press.
    e0 = cyc + 1;
    pushExpect(e0 + 6,  6'h08, 6'h08, "down_press");
    pushExpect(e0 + 15, 6'h00, 6'h00, "down_reset");
    pushExpect(e0 + 21, 6'h00, 6'h00, "down_repress_pre");
    pushExpect(e0 + 22, 6'h08, 6'h08, "down_repress");
    pushExpect(e0 + 35, 6'h00, 6'h08, "down_rel_hold");
    pushExpect(e0 + 36, 6'h00, 6'h00, "down_rel_fall");
    btn_raw = 6'h08;
    settle(15);
    rst_n = 1'b0;
    settle(1);
    rst_n = 1'b1;
    settle(14);
    btn_raw = 6'h00;
    settle(12);

    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_events got=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
